// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants and helpers for the N-way arbitrating mux
package mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Output stage occupancy: EMPTY means out_valid low, FULL means a word is held.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Ceiling log2, used to size channel indices from the channel count.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin picker: rotate requests by ptr, take lowest, map back
module rr_pick #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [SEL_W-1:0] pos;
    logic [SEL_W:0]   sum;

    // Rotate so ptr sits at bit 0, find the lowest request, then undo the rotation.
    always_comb begin
        dbl = {req, req};
        rot = dbl[ptr +: N];
        any = 1'b0;
        pos = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                any = 1'b1;
                pos = SEL_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, pos};
        if (int'(sum) >= N) begin
            idx = SEL_W'(int'(sum) - N);
        end else begin
            idx = sum[SEL_W-1:0];
        end
        grant = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/mux_arb_nway.sv
// rtl/mux_arb_nway.sv - N-way mux/arbiter with registered output; optional MUX_ARB_XFER_CNT_EN counter
module mux_arb_nway
    import mux_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 16,
    localparam int SEL_W = clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [SEL_W-1:0] ctrl_slct,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_chan,
    input  logic             out_ready,
    output logic             sel_err,
    output logic [15:0]      xfer_cnt
);

    logic [0:0]       state;
    logic [SEL_W-1:0] rr_ptr;
    logic [N-1:0]     rr_grant;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] g_idx;
    logic             fixed_ok;
    logic             can_load;
    logic             accept;
    logic [W-1:0]     sel_data;

    rr_pick #(.N(N), .SEL_W(SEL_W)) u_rr_pick (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    assign can_load  = (state == ST_EMPTY) | out_ready;
    assign out_valid = (state == ST_FULL);
    assign fixed_ok  = int'(ctrl_slct) < N;
    assign in_ready  = can_load ? grant : '0;
    assign accept    = can_load & (|(in_valid & grant));

    // Grant source: round-robin picker or the fixed select (out-of-range select grants nobody).
    always_comb begin
        grant = '0;
        g_idx = '0;
        if (mode == MODE_RR) begin
            grant = rr_any ? rr_grant : '0;
            g_idx = rr_idx;
        end else begin
            g_idx = ctrl_slct;
            if (fixed_ok) begin
                grant = N'(1) << ctrl_slct;
            end
        end
    end

    // Data mux written as a compare loop so an out-of-range index never slices past in_data.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (g_idx == SEL_W'(i)) begin
                sel_data = in_data[i*W +: W];
            end
        end
    end

    // Output stage: load on accept, drain when downstream takes the word, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_chan <= '0;
        end else if (accept) begin
            state    <= ST_FULL;
            out_data <= sel_data;
            out_chan <= g_idx;
        end else if (out_ready) begin
            state    <= ST_EMPTY;
        end
    end

    // Round-robin pointer moves just past the winner, only when a word is taken in rr mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept && mode == MODE_RR) begin
            if (int'(g_idx) == N - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= g_idx + SEL_W'(1);
            end
        end
    end

    // Sticky flag for a bad fixed select presented while the output could have taken a word.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (mode == MODE_FIXED && !fixed_ok && can_load) begin
            sel_err <= 1'b1;
        end
    end

`ifdef MUX_ARB_XFER_CNT_EN
    logic [15:0] cnt_q;

    // Accepted-word counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign xfer_cnt = cnt_q;
`else
    assign xfer_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mux_arb_nway.sv
// tb/tb_mux_arb_nway.sv - self-checking bench for mux_arb_nway (N=4 main, N=3 select-error case)
module tb_mux_arb_nway;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  ctrl_slct;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_chan;
    logic        out_ready;
    logic        sel_err;
    logic [15:0] xfer_cnt;

    logic        rst3;
    logic        mode3;
    logic [1:0]  ctrl_slct3;
    logic [2:0]  in_valid3;
    logic [47:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [15:0] out_data3;
    logic [1:0]  out_chan3;
    logic        out_ready3;
    logic        sel_err3;
    logic [15:0] xfer_cnt3;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    logic        m_full;
    logic [15:0] m_data;
    int          m_chan;
    int          m_ptr;
    logic        m_err;
    logic [15:0] m_cnt;

    // values sampled by the last step, for table comparisons
    logic [3:0]  s_rdy;
    logic        s_ov;
    logic [15:0] s_data;
    logic [1:0]  s_chan;

    always #5 clk = ~clk;

    mux_arb_nway #(.N(4), .W(16)) dut (
        .clk(clk), .rst(rst), .mode(mode), .ctrl_slct(ctrl_slct),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
        .out_ready(out_ready), .sel_err(sel_err), .xfer_cnt(xfer_cnt)
    );

    mux_arb_nway #(.N(3), .W(16)) dut3 (
        .clk(clk), .rst(rst3), .mode(mode3), .ctrl_slct(ctrl_slct3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_chan(out_chan3),
        .out_ready(out_ready3), .sel_err(sel_err3), .xfer_cnt(xfer_cnt3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic md, input logic [1:0] sl, input logic [3:0] v);
        if (!md) return int'(sl);
        for (int k = 0; k < 4; k++) begin
            if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_full = 1'b0; m_data = '0; m_chan = 0; m_ptr = 0; m_err = 1'b0; m_cnt = '0;
    endtask

    // One clock: apply inputs at negedge, check ready, clock, check registered outputs.
    task automatic step(input logic r, input logic md, input logic [1:0] sl,
                        input logic [3:0] v, input logic [63:0] d, input logic rdy);
        int   g;
        logic cl;
        logic acc;
        logic [3:0] e_rdy;
        rst = r; mode = md; ctrl_slct = sl; in_valid = v; in_data = d; out_ready = rdy;
        #1;
        g     = model_grant(md, sl, v);
        cl    = !m_full || rdy;
        e_rdy = (g >= 0 && cl) ? (4'b0001 << g) : 4'b0000;
        s_rdy = in_ready;
        chk("in_ready", {28'd0, in_ready}, {28'd0, e_rdy});
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            acc = (g >= 0) && v[g] && cl;
            if (acc) begin
                m_full = 1'b1;
                m_data = d[g*16 +: 16];
                m_chan = g;
                if (md) m_ptr = (g + 1) % 4;
`ifdef MUX_ARB_XFER_CNT_EN
                m_cnt = m_cnt + 16'd1;
`endif
            end else if (rdy) begin
                m_full = 1'b0;
            end
        end
        #1;
        s_ov = out_valid; s_data = out_data; s_chan = out_chan;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
        chk("out_data", {16'd0, out_data}, {16'd0, m_data});
        chk("out_chan", {30'd0, out_chan}, 32'(m_chan));
        chk("sel_err", {31'd0, sel_err}, {31'd0, m_err});
        chk("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, m_cnt});
        @(negedge clk);
    endtask

    typedef struct {
        logic       md;
        logic [1:0] sl;
        logic [3:0] v;
        logic       rdy;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [15:0] e_data;
        logic [1:0] e_chan;
    } vec_t;

    vec_t tbl[12];
    logic [63:0] dv;
    logic [15:0] e_cnt;

    initial begin
        dv = {16'hA003, 16'hBEEF, 16'hA001, 16'hA000};
        tbl[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2};
        tbl[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 16'hA000, 2'd0};
        tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 16'hA001, 2'd1};
        tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2};
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 16'hA003, 2'd3};
        tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 16'hA000, 2'd0};
        tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 16'hA001, 2'd1};
        tbl[7]  = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 16'hA001, 2'd1};
        tbl[8]  = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 16'hA001, 2'd1};
        tbl[9]  = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 16'hA001, 2'd1};
        tbl[10] = '{1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 16'hA003, 2'd3};
        tbl[11] = '{1'b0, 2'd3, 4'b0000, 1'b1, 4'b1000, 1'b0, 16'hA003, 2'd3};

        rst = 1'b1; mode = 1'b0; ctrl_slct = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        rst3 = 1'b1; mode3 = 1'b0; ctrl_slct3 = '0; in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b1;
        model_reset();

        // N=3: out-of-range fixed select grants nobody and latches sel_err until reset
        @(negedge clk); @(negedge clk);
        rst3 = 1'b0; ctrl_slct3 = 2'd3; in_valid3 = 3'b111; in_data3 = {16'h3333, 16'h2222, 16'h1111};
        #1;
        chk("n3_in_ready_bad_sel", {29'd0, in_ready3}, 32'd0);
        @(posedge clk); #1;
        chk("n3_out_valid", {31'd0, out_valid3}, 32'd0);
        chk("n3_sel_err_set", {31'd0, sel_err3}, 32'd1);
        @(negedge clk);
        ctrl_slct3 = 2'd0; in_valid3 = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("n3_sel_err_sticky", {31'd0, sel_err3}, 32'd1);
            chk("n3_out_valid_idle", {31'd0, out_valid3}, 32'd0);
        end
        @(negedge clk);
        rst3 = 1'b1;
        @(posedge clk); #1;
        chk("n3_sel_err_cleared", {31'd0, sel_err3}, 32'd0);
        @(negedge clk);
        rst3 = 1'b0;

        // reset state of the main instance
        step(1'b1, 1'b0, 2'd0, 4'b1111, dv, 1'b1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_chan", {30'd0, out_chan}, 32'd0);
        chk("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);

        // directed table: fixed select, rr rotation, backpressure hold, drain+load
        for (int i = 0; i < 12; i++) begin
            step(1'b0, tbl[i].md, tbl[i].sl, tbl[i].v, dv, tbl[i].rdy);
            chk($sformatf("tbl%0d_in_ready", i), {28'd0, s_rdy}, {28'd0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_out_valid", i), {31'd0, s_ov}, {31'd0, tbl[i].e_ov});
            chk($sformatf("tbl%0d_out_data", i), {16'd0, s_data}, {16'd0, tbl[i].e_data});
            chk($sformatf("tbl%0d_out_chan", i), {30'd0, s_chan}, {30'd0, tbl[i].e_chan});
        end

        // rr mid-stream reset: load chan1 (ptr -> 2), reset, next grant from channel 0
        step(1'b0, 1'b1, 2'd0, 4'b0010, dv, 1'b1);
        chk("pre_rst_chan", {30'd0, s_chan}, 32'd1);
        step(1'b1, 1'b1, 2'd0, 4'b1111, dv, 1'b1);
        chk("mid_rst_out_valid", {31'd0, s_ov}, 32'd0);
        step(1'b0, 1'b1, 2'd0, 4'b1111, dv, 1'b1);
        chk("post_rst_grant", {28'd0, s_rdy}, 32'd1);
        chk("post_rst_chan", {30'd0, s_chan}, 32'd0);

        // five accepts then counter value
        step(1'b1, 1'b0, 2'd0, 4'b0000, dv, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'd0, 4'b0001, dv, 1'b1);
`ifdef MUX_ARB_XFER_CNT_EN
        e_cnt = 16'd5;
`else
        e_cnt = 16'd0;
`endif
        chk("xfer_cnt_after_5", {16'd0, xfer_cnt}, {16'd0, e_cnt});

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom), 2'($urandom), 4'($urandom),
                 {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
